// File: rtl/i2c_nco_master.sv
// i2c_nco_master: write-only I2C master that programs the NCO configuration slave.
// One transaction is START, {ADDRESS,W}, control byte, 0/8/2 payload bytes, STOP,
// with the slave ACK checked after every byte and an early STOP on NACK.
// Every bit is four quarter periods: Q0 scl low/set sda, Q1 scl rises,
// Q2 scl high/sample, Q3 scl falls.
module i2c_nco_master #(
    parameter logic [6:0] ADDRESS = 7'b1101010,
    parameter int         CLK_DIV = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic        enable_in,
    input  logic [1:0]  wave_in,
    input  logic [63:0] freq_in,
    input  logic [15:0] duty_in,
    output logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        done,
    output logic        nack_err
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_TX_BYTE = 3'd2,
        ST_RX_ACK  = 3'd3,
        ST_STOP    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic               tick_s;
    logic               accept_s;
    logic [1:0]         q_r, q_s;
    logic [2:0]         bit_cnt_r, bit_cnt_s;
    logic [3:0]         byte_cnt_r, byte_cnt_s;
    logic [3:0]         last_byte_r;
    logic [7:0]         shift_r, shift_s;
    logic [63:0]        payload_r, payload_s;
    logic [7:0]         ctrl_r;
    logic               ack_r;
    logic               nack_set_s;
    logic               nack_err_r;
    logic               scl_s, scl_r;
    logic               sda_oe_s, sda_oe_r;
    logic               busy_r, done_r;
    logic               sda_meta_r, sda_sync_r;

    // Control byte layout: {000, upd_duty, upd_freq, wave, enable}; cmd 11 acts as 00.
    function automatic logic [7:0] make_ctrl(input logic [1:0] c, input logic [1:0] w,
                                             input logic en);
        make_ctrl = {3'b000, (c == 2'b10), (c == 2'b01), w, en};
    endfunction

    // Index of the final byte (0 = address): 1 + payload byte count.
    function automatic logic [3:0] make_last(input logic [1:0] c);
        case (c)
            2'b01:   make_last = 4'd9;
            2'b10:   make_last = 4'd3;
            default: make_last = 4'd1;
        endcase
    endfunction

    assign tick_s   = (div_cnt_r == DIV_W'(CLK_DIV - 1));
    assign accept_s = (state_r == ST_IDLE) && start;

    // Next-state, quarter/bit/byte sequencing and shift register loading.
    always_comb begin
        state_s    = state_r;
        q_s        = q_r;
        bit_cnt_s  = bit_cnt_r;
        byte_cnt_s = byte_cnt_r;
        shift_s    = shift_r;
        payload_s  = payload_r;
        nack_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_START;
                    q_s        = 2'd0;
                    bit_cnt_s  = 3'd7;
                    byte_cnt_s = 4'd0;
                    shift_s    = {ADDRESS, 1'b0};
                    if (cmd == 2'b01) begin
                        payload_s = freq_in;
                    end else if (cmd == 2'b10) begin
                        payload_s = {duty_in, 48'h0000_0000_0000};
                    end else begin
                        payload_s = 64'h0000_0000_0000_0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (q_r == 2'd2) begin
                        state_s = ST_TX_BYTE;
                        q_s     = 2'd0;
                    end else begin
                        q_s = q_r + 2'd1;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            ST_TX_BYTE: begin
                if (tick_s) begin
                    if (q_r == 2'd3) begin
                        q_s = 2'd0;
                        if (bit_cnt_r == 3'd0) begin
                            state_s = ST_RX_ACK;
                        end else begin
                            bit_cnt_s = bit_cnt_r - 3'd1;
                            shift_s   = {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        q_s = q_r + 2'd1;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            ST_RX_ACK: begin
                if (tick_s) begin
                    if (q_r == 2'd3) begin
                        q_s = 2'd0;
                        if (ack_r) begin
                            state_s    = ST_STOP;
                            nack_set_s = 1'b1;
                        end else if (byte_cnt_r == last_byte_r) begin
                            state_s = ST_STOP;
                        end else begin
                            state_s    = ST_TX_BYTE;
                            bit_cnt_s  = 3'd7;
                            byte_cnt_s = byte_cnt_r + 4'd1;
                            if (byte_cnt_r == 4'd0) begin
                                shift_s = ctrl_r;
                            end else begin
                                shift_s   = payload_r[63:56];
                                payload_s = {payload_r[55:0], 8'h00};
                            end
                        end
                    end else begin
                        q_s = q_r + 2'd1;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (q_r == 2'd2) begin
                        state_s = ST_DONE;
                        q_s     = 2'd0;
                    end else begin
                        q_s = q_r + 2'd1;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pin levels for the upcoming state/quarter; registered below so outputs are glitch-free.
    always_comb begin
        scl_s    = 1'b1;
        sda_oe_s = 1'b0;
        case (state_s)
            ST_START: begin
                scl_s    = (q_s != 2'd2);
                sda_oe_s = (q_s != 2'd0);
            end
            ST_TX_BYTE: begin
                scl_s    = (q_s == 2'd1) || (q_s == 2'd2);
                sda_oe_s = ~shift_s[7];
            end
            ST_RX_ACK: begin
                scl_s    = (q_s == 2'd1) || (q_s == 2'd2);
                sda_oe_s = 1'b0;
            end
            ST_STOP: begin
                scl_s    = (q_s != 2'd0);
                sda_oe_s = (q_s != 2'd2);
            end
            default: begin
                scl_s    = 1'b1;
                sda_oe_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and quarter-tick divider; the divider restarts on every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= '0;
            q_r        <= 2'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 4'd0;
            shift_r    <= 8'h00;
            payload_r  <= 64'h0000_0000_0000_0000;
        end else begin
            state_r    <= state_s;
            q_r        <= q_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            shift_r    <= shift_s;
            payload_r  <= payload_s;
            if ((state_r == ST_IDLE) || (state_r == ST_DONE) || tick_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end
    end

    // Request capture, ACK sampling at the end of Q2 and sticky NACK flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r      <= 8'h00;
            last_byte_r <= 4'd0;
            ack_r       <= 1'b0;
            nack_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                ctrl_r      <= make_ctrl(cmd, wave_in, enable_in);
                last_byte_r <= make_last(cmd);
                nack_err_r  <= 1'b0;
            end else if (nack_set_s) begin
                nack_err_r  <= 1'b1;
            end
            if ((state_r == ST_RX_ACK) && tick_s && (q_r == 2'd2)) begin
                ack_r <= sda_sync_r;
            end
        end
    end

    // Two-flop synchroniser for the bus data line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Registered pin and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_r    <= 1'b1;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            scl_r    <= scl_s;
            sda_oe_r <= sda_oe_s;
            busy_r   <= (state_s == ST_START) || (state_s == ST_TX_BYTE) ||
                        (state_s == ST_RX_ACK) || (state_s == ST_STOP);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign scl      = scl_r;
    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign busy     = busy_r;
    assign done     = done_r;
    assign nack_err = nack_err_r;

endmodule

// File: tb/tb_i2c_nco_master.sv
// tb_i2c_nco_master: directed bench with an I2C slave/bus model and a protocol monitor.
module tb_i2c_nco_master;

    localparam int CD    = 4;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cmd;
    logic        enable_in;
    logic [1:0]  wave_in;
    logic [63:0] freq_in;
    logic [15:0] duty_in;
    logic        scl;
    wire         sda;
    logic        busy;
    logic        done;
    logic        nack_err;

    logic        slv_drive = 1'b0;
    logic        nack_mode = 1'b0;
    wire         sda_s = (sda === 1'b0) ? 1'b0 : 1'b1;

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    i2c_nco_master #(.ADDRESS(7'b1101010), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .enable_in(enable_in),
        .wave_in(wave_in), .freq_in(freq_in), .duty_in(duty_in),
        .scl(scl), .sda(sda), .busy(busy), .done(done), .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave model, sampled mid-cycle.
    int         edge_viol  = 0;
    int         width_err  = 0;
    int         width_seen = 0;
    int         start_cnt  = 0;
    int         stop_cnt   = 0;
    int         run_len    = 0;
    logic       run_busy   = 1'b0;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    int         bit_cnt    = 0;
    int         byte_idx   = 0;
    logic [7:0] shreg      = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda_s;
        if (scl !== prev_scl) begin
            if (sda_s !== prev_sda) edge_viol <= edge_viol + 1;
            if (run_busy) begin
                width_seen <= width_seen + 1;
                if (run_len != 2 * CD) width_err <= width_err + 1;
            end
            run_len  <= 1;
            run_busy <= busy;
            if (scl) begin
                if (bit_cnt < 8) begin
                    shreg   <= {shreg[6:0], sda_s};
                    bit_cnt <= bit_cnt + 1;
                    if (bit_cnt == 7) rx_q.push_back({shreg[6:0], sda_s});
                end else if (bit_cnt == 8) begin
                    bit_cnt <= 9;
                end
            end else begin
                if (bit_cnt == 8) begin
                    slv_drive <= !(nack_mode && (byte_idx == 0));
                end else if (bit_cnt == 9) begin
                    slv_drive <= 1'b0;
                    bit_cnt   <= 0;
                    byte_idx  <= byte_idx + 1;
                end
            end
        end else begin
            run_len <= run_len + 1;
            if (!busy) run_busy <= 1'b0;
            if (scl && (sda_s !== prev_sda)) begin
                bit_cnt   <= 0;
                slv_drive <= 1'b0;
                if (!sda_s) begin
                    start_cnt <= start_cnt + 1;
                    byte_idx  <= 0;
                    rx_q.delete();
                end else begin
                    stop_cnt <= stop_cnt + 1;
                end
            end
        end
    end

    int b_viol, b_werr, b_wseen, b_start, b_stop;

    // Run one transaction and check timing, done pulse, nack_err and bus protocol.
    task automatic run_txn(input string tag, input logic [1:0] c, input logic en,
                           input logic [1:0] wv, input logic [63:0] f, input logic [15:0] d,
                           input int poke_at, input int exp_quarters, input logic exp_nack);
        int n;
        int done_in_busy;
        b_viol = edge_viol; b_werr = width_err; b_wseen = width_seen;
        b_start = start_cnt; b_stop = stop_cnt;
        @(posedge clk); #1;
        cmd = c; enable_in = en; wave_in = wv; freq_in = f; duty_in = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_nack_clr"}, 64'(nack_err), 64'd0);
        n = 0;
        done_in_busy = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            if (n == poke_at) begin
                start = 1'b1; freq_in = ~freq_in; cmd = 2'b10;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) done_in_busy++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check_eq({tag, "_busy_clks"}, 64'(n), 64'(exp_quarters * CD));
        check_eq({tag, "_done_hi"}, 64'(done), 64'd1);
        check_eq({tag, "_nack"}, 64'(nack_err), 64'(exp_nack));
        check_eq({tag, "_done_early"}, 64'(done_in_busy), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_done_1clk"}, 64'(done), 64'd0);
        check_eq({tag, "_nack_hold"}, 64'(nack_err), 64'(exp_nack));
        check_eq({tag, "_idle_scl"}, 64'(scl), 64'd1);
        check_eq({tag, "_edge_viol"}, 64'(edge_viol - b_viol), 64'd0);
        check_eq({tag, "_scl_width"}, 64'(width_err - b_werr), 64'd0);
        check_eq({tag, "_width_seen"}, 64'((width_seen - b_wseen) > 0), 64'd1);
        check_eq({tag, "_starts"}, 64'(start_cnt - b_start), 64'd1);
        check_eq({tag, "_stops"}, 64'(stop_cnt - b_stop), 64'd1);
    endtask

    task automatic expect_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3,
                                input logic [7:0] e4, input logic [7:0] e5,
                                input logic [7:0] e6, input logic [7:0] e7,
                                input logic [7:0] e8, input logic [7:0] e9, input int n);
        logic [7:0] e [10];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8, e9};
        check_eq({tag, "_nbytes"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(e[i]));
        end
    endtask

    initial begin
        logic [63:0] rebuilt;
        rst = 1'b1; start = 1'b0; cmd = 2'b00; enable_in = 1'b0; wave_in = 2'b00;
        freq_in = 64'h0; duty_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_scl", 64'(scl), 64'd1);
        check_eq("rst_sda", 64'(sda_s), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_nack", 64'(nack_err), 64'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 1) control only
        run_txn("t1", 2'b00, 1'b1, 2'b10, 64'h0, 16'h0, -1, 78, 1'b0);
        expect_bytes("t1", 8'hD4, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 2);

        // 2) frequency update
        run_txn("t2", 2'b01, 1'b0, 2'b00, 64'h0123_4567_89AB_CDEF, 16'h0, -1, 366, 1'b0);
        expect_bytes("t2", 8'hD4, 8'h08, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                     8'hCD, 8'hEF, 10);
        rebuilt = 64'h0;
        for (int i = 2; i < 10; i++) rebuilt = {rebuilt[55:0], rx_q[i]};
        check_eq("t2_freq_rebuilt", rebuilt, 64'h0123_4567_89AB_CDEF);

        // 3) duty update
        run_txn("t3", 2'b10, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 16'h8000, -1, 150, 1'b0);
        expect_bytes("t3", 8'hD4, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 4);

        // 4) address NACK
        nack_mode = 1'b1;
        run_txn("t4", 2'b01, 1'b1, 2'b01, 64'h1, 16'h0, -1, 42, 1'b1);
        expect_bytes("t4", 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 1);
        nack_mode = 1'b0;

        // 5) start + input change mid-transaction are ignored
        run_txn("t5", 2'b01, 1'b1, 2'b01, 64'h1122_3344_5566_7788, 16'h0, 200, 366, 1'b0);
        expect_bytes("t5", 8'hD4, 8'h0B, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                     8'h77, 8'h88, 10);

        // 5b) reset in Q1 of the third address bit (a driven 0)
        @(posedge clk); #1;
        cmd = 2'b00; enable_in = 1'b1; wave_in = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12 * CD + 1) @(posedge clk);
        #1;
        check_eq("t5r_pre_scl", 64'(scl), 64'd1);
        check_eq("t5r_pre_sda", 64'(sda_s), 64'd0);
        check_eq("t5r_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t5r_scl", 64'(scl), 64'd1);
        check_eq("t5r_sda", 64'(sda_s), 64'd1);
        check_eq("t5r_slave_idle", 64'(slv_drive), 64'd0);
        check_eq("t5r_busy", 64'(busy), 64'd0);
        check_eq("t5r_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // 6) recovery after reset; cmd 11 behaves as control only
        run_txn("t6", 2'b11, 1'b1, 2'b11, 64'hAAAA_0000_5555_FFFF, 16'h1234, -1, 78, 1'b0);
        expect_bytes("t6", 8'hD4, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
